// File: rtl/inert_pkg.sv
// Shared types and SPI command words for the inertial-sensor yaw readout sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT1,
    INIT2,
    INIT3,
    IDLE,
    YAWL,
    YAWH
  } state_t;

  // Command word layout: [15] read, [14:8] register address, [7:0] write data
  localparam logic [15:0] CMD_INIT1 = 16'h0D02;  // data-ready interrupt enable
  localparam logic [15:0] CMD_INIT2 = 16'h1160;  // gyro output data rate
  localparam logic [15:0] CMD_INIT3 = 16'h1440;  // rounding mode
  localparam logic [15:0] CMD_YAWL  = 16'hA600;  // read yaw rate low byte
  localparam logic [15:0] CMD_YAWH  = 16'hA700;  // read yaw rate high byte

endpackage

// File: rtl/inert_spi_seq_if.sv
// Handshake between the sequencer and the SPI master: request/command out, completion/read data back.
interface inert_spi_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] inert_data;

  modport master (output wrt, output cmd, input done, input inert_data);
  modport slave  (input wrt, input cmd, output done, output inert_data);
endinterface

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the sensor's data-ready interrupt into the clk domain.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], async_in};
    end
  end

  assign sync_out = sync_reg[1];

endmodule

// File: rtl/inert_spi_seq.sv
// Sensor bring-up and yaw-rate readout: waits out power-up, writes three config registers,
// then reads the 16-bit yaw rate (low byte, then high byte) on every data-ready interrupt.
module inert_spi_seq
  import inert_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INT,
  inert_spi_seq_if.master         spi,
  output logic [15:0]             yaw_rt,
  output logic                    vld
);

  localparam logic [15:0] PWR_TC = (FAST_SIM != 0) ? 16'h03FF : 16'hFFFF;

  state_t      state_reg;
  logic [15:0] pwr_cnt_reg;
  logic        wrt_reg;
  logic        vld_reg;
  logic [15:0] cmd_reg;
  logic [15:0] yaw_rt_reg;
  logic [7:0]  low_byte_reg;
  logic        int_synced;
  logic        xfer_done;
  logic        unused_data_hi;

  int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .sync_out (int_synced)
  );

  // A done arriving alongside the request cannot belong to the new transaction.
  assign xfer_done      = spi.done && !wrt_reg;
  assign unused_data_hi = ^spi.inert_data[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= PWRUP;
      pwr_cnt_reg  <= '0;
      wrt_reg      <= 1'b0;
      vld_reg      <= 1'b0;
      cmd_reg      <= '0;
      yaw_rt_reg   <= '0;
      low_byte_reg <= '0;
    end else begin
      wrt_reg <= 1'b0;
      vld_reg <= 1'b0;
      case (state_reg)
        PWRUP: begin
          // Counter parks at terminal count, so it can never wrap
          if (pwr_cnt_reg == PWR_TC) begin
            state_reg <= INIT1;
            wrt_reg   <= 1'b1;
            cmd_reg   <= CMD_INIT1;
          end else begin
            pwr_cnt_reg <= pwr_cnt_reg + 16'd1;
          end
        end
        INIT1: if (xfer_done) begin
          state_reg <= INIT2;
          wrt_reg   <= 1'b1;
          cmd_reg   <= CMD_INIT2;
        end
        INIT2: if (xfer_done) begin
          state_reg <= INIT3;
          wrt_reg   <= 1'b1;
          cmd_reg   <= CMD_INIT3;
        end
        INIT3: if (xfer_done) begin
          state_reg <= IDLE;
        end
        IDLE: if (int_synced) begin
          state_reg <= YAWL;
          wrt_reg   <= 1'b1;
          cmd_reg   <= CMD_YAWL;
        end
        YAWL: if (xfer_done) begin
          low_byte_reg <= spi.inert_data[7:0];
          state_reg    <= YAWH;
          wrt_reg      <= 1'b1;
          cmd_reg      <= CMD_YAWH;
        end
        YAWH: if (xfer_done) begin
          yaw_rt_reg <= {spi.inert_data[7:0], low_byte_reg};
          vld_reg    <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= PWRUP;
      endcase
    end
  end

  assign spi.wrt = wrt_reg;
  assign spi.cmd = cmd_reg;
  assign yaw_rt  = yaw_rt_reg;
  assign vld     = vld_reg;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq: init sequence, yaw samples from a vector table, reset abort.
module tb_inert_spi_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_in = 1'b0;
  logic [15:0] yaw_rt;
  logic        vld;

  inert_spi_seq_if spi_bus ();

  inert_spi_seq #(.FAST_SIM(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .INT    (int_in),
    .spi    (spi_bus),
    .yaw_rt (yaw_rt),
    .vld    (vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vld_cnt = 0;
  int last_vld_cyc = 0;
  int rel_cyc = 0;
  logic [15:0] wrt_cmd_q[$];
  int          wrt_cyc_q[$];

  typedef struct {
    logic        hold;   // keep INT high so the next sample follows back-to-back
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] exp_yaw;
  } yaw_vec_t;

  yaw_vec_t    yaw_tab[4];
  logic [15:0] init_tab[3];

  // Transaction monitor: one line per SPI request and per yaw update
  always @(posedge clk) begin
    #1;
    cyc++;
    if (spi_bus.wrt) begin
      wrt_cmd_q.push_back(spi_bus.cmd);
      wrt_cyc_q.push_back(cyc);
      $display("cyc=%0d wrt cmd=%h", cyc, spi_bus.cmd);
    end
    if (vld) begin
      vld_cnt++;
      last_vld_cyc = cyc;
      $display("cyc=%0d vld yaw_rt=%h", cyc, yaw_rt);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_wrt(input int budget, output logic [15:0] c, output int wc);
    c  = '0;
    wc = -1;
    for (int i = 0; i < budget; i++) begin
      if (wrt_cmd_q.size() > 0) break;
      @(negedge clk);
    end
    if (wrt_cmd_q.size() > 0) begin
      c  = wrt_cmd_q.pop_front();
      wc = wrt_cyc_q.pop_front();
    end else begin
      total++;
      bad++;
      $display("FAIL wrt_timeout got=none exp=wrt within %0d cycles", budget);
    end
  endtask

  task automatic respond(input logic [15:0] d);
    repeat (4) @(negedge clk);
    spi_bus.done       = 1'b1;
    spi_bus.inert_data = d;
    @(negedge clk);
    spi_bus.done       = 1'b0;
    spi_bus.inert_data = 16'h0000;
  endtask

  task automatic run_init();
    logic [15:0] c;
    int          wc;
    for (int i = 0; i < 3; i++) begin
      wait_wrt((i == 0) ? 1100 : 20, c, wc);
      if (i == 0) check_range("pwrup_wait", wc - rel_cyc, 1023, 1025);
      check($sformatf("init_cmd%0d", i), c, init_tab[i]);
      if (i == 1) begin
        // interrupt during init must be dropped, not queued
        @(negedge clk);
        int_in = 1'b1;
        repeat (3) @(negedge clk);
        int_in = 1'b0;
      end
      respond(16'h0000);
    end
  endtask

  initial begin
    logic [15:0] c;
    int          wc;
    int          vprev;
    logic        prev_hold;

    init_tab[0] = 16'h0D02;
    init_tab[1] = 16'h1160;
    init_tab[2] = 16'h1440;
    yaw_tab[0] = '{1'b0, 16'h0034, 16'h00F2, 16'hF234};
    yaw_tab[1] = '{1'b1, 16'h0001, 16'h0080, 16'h8001};
    yaw_tab[2] = '{1'b0, 16'h0002, 16'h0080, 16'h8002};
    yaw_tab[3] = '{1'b0, 16'hFF10, 16'hAB7F, 16'h7F10};

    spi_bus.done       = 1'b0;
    spi_bus.inert_data = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_wrt", spi_bus.wrt, 1'b0);
    check("rst_vld", vld, 1'b0);
    check("rst_cmd", spi_bus.cmd, 16'h0000);
    check("rst_yaw", yaw_rt, 16'h0000);

    rst     = 1'b0;
    rel_cyc = cyc;
    run_init();

    repeat (40) @(negedge clk);
    check("idle_no_wrt", wrt_cmd_q.size(), 0);
    spi_bus.done = 1'b1;
    @(negedge clk);
    spi_bus.done = 1'b0;
    repeat (20) @(negedge clk);
    check("spurious_done_no_wrt", wrt_cmd_q.size(), 0);
    check("spurious_done_no_vld", vld_cnt, 0);

    prev_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!prev_hold) begin
        int_in = 1'b1;
        vprev  = cyc;
        wait_wrt(20, c, wc);
        check_range($sformatf("int_latency%0d", i), wc - vprev, 2, 3);
      end else begin
        wait_wrt(20, c, wc);
        check($sformatf("b2b_gap%0d", i), wc - last_vld_cyc, 1);
      end
      check($sformatf("yawl_cmd%0d", i), c, 16'hA600);
      if (!yaw_tab[i].hold) int_in = 1'b0;
      respond(yaw_tab[i].lo);
      wait_wrt(20, c, wc);
      check($sformatf("yawh_cmd%0d", i), c, 16'hA700);
      vprev = vld_cnt;
      respond(yaw_tab[i].hi);
      check($sformatf("vld_once%0d", i), vld_cnt, vprev + 1);
      check($sformatf("yaw_rt%0d", i), yaw_rt, yaw_tab[i].exp_yaw);
      prev_hold = yaw_tab[i].hold;
    end

    repeat (20) @(negedge clk);
    check("yaw_hold", yaw_rt, 16'h7F10);
    check("vld_total", vld_cnt, 4);
    check("after_samples_no_wrt", wrt_cmd_q.size(), 0);

    // Reset while the high-byte read is outstanding
    int_in = 1'b1;
    wait_wrt(20, c, wc);
    check("abort_yawl_cmd", c, 16'hA600);
    int_in = 1'b0;
    respond(16'h0055);
    wait_wrt(20, c, wc);
    check("abort_yawh_cmd", c, 16'hA700);
    repeat (2) @(negedge clk);
    vprev = vld_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_wrt", spi_bus.wrt, 1'b0);
    check("abort_rst_vld", vld, 1'b0);
    check("abort_rst_cmd", spi_bus.cmd, 16'h0000);
    check("abort_rst_yaw", yaw_rt, 16'h0000);
    repeat (3) @(negedge clk);
    wrt_cmd_q.delete();
    wrt_cyc_q.delete();
    rst     = 1'b0;
    rel_cyc = cyc;
    run_init();
    check("abort_no_vld", vld_cnt, vprev);
    check("abort_yaw_zero", yaw_rt, 16'h0000);
    repeat (20) @(negedge clk);
    check("abort_idle_no_wrt", wrt_cmd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inert_spi_seq.md
INERT_SPI_SEQ -- requirements
Module: inert_spi_seq

Interface
REQ-001 Parameter: FAST_SIM, default 1, selects a shortened power-up wait (1 = 2^10 clocks, 0 = 2^16 clocks).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 INT  input  1  raw data-ready interrupt from inertial sensor, asynchronous to clk.
REQ-005 done  input  1  one-cycle pulse from SPI master: transaction complete.
REQ-006 inert_data  input  16  SPI master read data; the register byte is in [7:0].
REQ-007 wrt  output  1  one-cycle pulse requesting an SPI transaction.
REQ-008 cmd  output  16  SPI command word: [15] = read, [14:8] = address, [7:0] = write data.
REQ-009 yaw_rt  output  16  signed yaw rate, last complete sample.
REQ-010 vld  output  1  one-cycle pulse when yaw_rt updates.

Function
REQ-011 States: PWRUP, INIT1, INIT2, INIT3, IDLE, YAWL, YAWH; leave PWRUP only when the power-up counter reaches terminal count.
REQ-012 INIT1 issues cmd 16'h0D02 (interrupt enable), INIT2 issues 16'h1160 (gyro ODR), and INIT3 issues 16'h1440 (rounding); each state advances on done.
REQ-013 wrt pulses high for exactly one cycle, on the first cycle of each transaction state (INIT1..INIT3, YAWL, YAWH).
REQ-014 cmd becomes valid in the cycle wrt is high and holds until done is sampled; otherwise cmd holds its last value.
REQ-015 INT passes through a two-flop synchronizer; IDLE samples only the synchronized value, giving 2-3 cycles latency from INT rise to the YAWL wrt.
REQ-016 The block leaves IDLE for YAWL when synchronized INT is high; YAWL issues 16'hA600 (read yaw low).
REQ-017 On done in YAWL, the block latches inert_data[7:0] into an internal low-byte register and enters YAWH, which issues 16'hA700 (read yaw high).
REQ-018 On done in YAWH, yaw_rt <= {inert_data[7:0], low_byte}, vld pulses in that same register update (one cycle), and the block returns to IDLE.
REQ-019 If synchronized INT is still high on return to IDLE, a new YAWL starts on the next cycle; no minimum gap is required.
REQ-020 INT is ignored in PWRUP, INIT1..INIT3, YAWL, and YAWH; no pending interrupt is queued.
REQ-021 done is ignored in PWRUP and IDLE; a done pulse coincident with wrt is ignored (it belongs to no transaction).
REQ-022 yaw_rt changes only on vld; between samples it holds its value.
REQ-023 The power-up counter is 16 bits and does not wrap: it saturates until reset.

Reset
REQ-024 rst asserted: state = PWRUP, power-up counter = 0, wrt = 0, vld = 0, cmd = 16'h0000, yaw_rt = 16'h0000, low byte = 0, synchronizer flops = 0.
REQ-025 rst mid-transaction aborts immediately; after release, the block repeats the full power-up and init sequence.
REQ-026 No output is asserted while rst is high.

Structure
REQ-027 Shared package inert_pkg holds the state enum typedef and the five cmd constants (INIT1/2/3, YAWL, YAWH).
REQ-028 The INT two-flop synchronizer is the only sub-module, int_sync (clk, rst, async_in, sync_out).
REQ-029 Implementation uses one state register, one power-up counter, and registered wrt/vld/cmd/yaw_rt; there is no combinational path from inputs to outputs.

Verification
REQ-030 Release rst with FAST_SIM=1 -> first wrt at 1024 +/- 1 cycles with cmd 16'h0D02; no wrt earlier.
REQ-031 Return done 5 cycles after each wrt -> wrt sequence 16'h0D02, 16'h1160, 16'h1440, then no further wrt while INT = 0.
REQ-032 After init, raise INT, respond inert_data 16'h0034 then 16'h00F2 -> cmds 16'hA600, 16'hA700; yaw_rt = 16'hF234 and exactly one vld pulse.
REQ-033 Hold INT high across two samples with data 16'h0001/16'h0080, then 16'h0002/16'h0080 -> yaw_rt 16'h8001 then 16'h8002, two vld pulses, no idle gap beyond one cycle.
REQ-034 Pulse INT during INIT2 and spurious done in IDLE -> no extra wrt, no vld, state sequence unchanged.
REQ-035 Assert rst between YAWL done and YAWH done -> wrt stays low, vld never pulses, yaw_rt = 0, and the init sequence restarts after power-up wait.
